t09_pulse_stretcher: RTL

T09_PULSE_STRETCHER -- requirements
Module: t09_pulse_stretcher

---
 rtl/t09_pkg.sv | 27 ++
 rtl/t09_stretch_ch.sv | 39 +++
 rtl/t09_pulse_stretcher.sv | 87 ++++++++
 3 files changed

// File: rtl/t09_pkg.sv
// rtl/t09_pkg.sv - shared direction encodings and helpers for the pulse stretcher
package t09_pkg;

  localparam logic [3:0] DIR_UP    = 4'b1000;
  localparam logic [3:0] DIR_DOWN  = 4'b0100;
  localparam logic [3:0] DIR_LEFT  = 4'b0010;
  localparam logic [3:0] DIR_RIGHT = 4'b0001;
  localparam logic [3:0] DIR_RESET = DIR_RIGHT;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

  // A non-one-hot argument maps to zero so it can never match a real pulse.
  function automatic logic [3:0] opposite_dir(input logic [3:0] d);
    logic [3:0] r;
    case (d)
      DIR_UP:    r = DIR_DOWN;
      DIR_DOWN:  r = DIR_UP;
      DIR_LEFT:  r = DIR_RIGHT;
      DIR_RIGHT: r = DIR_LEFT;
      default:   r = 4'b0000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/t09_stretch_ch.sv
// rtl/t09_stretch_ch.sv - one stretch channel: down-counter with load/clear and level output
module t09_stretch_ch #(
  parameter int unsigned LEN   = 10,
  parameter int unsigned CNT_W = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic clear_i,
  output logic level_o
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LEN);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear beats load so a cancelling event always wins within the same cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign level_o = (cnt_q != '0);

endmodule

// File: rtl/t09_pulse_stretcher.sv
// rtl/t09_pulse_stretcher.sv - stretches game event pulses and tracks direction / game-over state
module t09_pulse_stretcher
  import t09_pkg::*;
#(
  parameter int unsigned STRETCH_LEN = 10,
  parameter int unsigned CNT_W       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       goodColl_p,
  input  logic       badColl_p,
  input  logic       button_p,
  input  logic [3:0] direction_p,
  input  logic       dir_ack,
  output logic       goodColl_s,
  output logic       badColl_s,
  output logic       button_s,
  output logic [3:0] dir_q,
  output logic       dir_changed,
  output logic       game_over
);

  if ((STRETCH_LEN < 1) || (STRETCH_LEN > (2 ** CNT_W) - 1)) begin : g_len_check
    $error("STRETCH_LEN must lie in 1 .. 2^CNT_W-1");
  end

  logic       good_clear;
  logic [3:0] dir_cur_q, dir_cur_d;
  logic       dir_chg_q, dir_chg_d;
  logic       game_over_q, game_over_d;
  logic       dir_accept;

  // A bad collision in the same cycle cancels the good one.
  assign good_clear = goodColl_p & badColl_p;

  t09_stretch_ch #(.LEN(STRETCH_LEN), .CNT_W(CNT_W)) u_good_ch (
    .clk     (clk),
    .rst     (rst),
    .load_i  (goodColl_p),
    .clear_i (good_clear),
    .level_o (goodColl_s)
  );

  t09_stretch_ch #(.LEN(STRETCH_LEN), .CNT_W(CNT_W)) u_bad_ch (
    .clk     (clk),
    .rst     (rst),
    .load_i  (badColl_p),
    .clear_i (1'b0),
    .level_o (badColl_s)
  );

  t09_stretch_ch #(.LEN(STRETCH_LEN), .CNT_W(CNT_W)) u_button_ch (
    .clk     (clk),
    .rst     (rst),
    .load_i  (button_p),
    .clear_i (1'b0),
    .level_o (button_s)
  );

  always_comb begin
    dir_accept  = is_onehot4(direction_p)
                  && (direction_p != opposite_dir(dir_cur_q))
                  && (direction_p != dir_cur_q)
                  && !game_over_q;
    dir_cur_d   = dir_accept ? direction_p : dir_cur_q;
    // A fresh update in the ack cycle keeps the flag set so it is not lost.
    dir_chg_d   = dir_accept | (dir_chg_q & ~dir_ack);
    game_over_d = game_over_q | badColl_p;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dir_cur_q   <= DIR_RESET;
      dir_chg_q   <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      dir_cur_q   <= dir_cur_d;
      dir_chg_q   <= dir_chg_d;
      game_over_q <= game_over_d;
    end
  end

  assign dir_q       = dir_cur_q;
  assign dir_changed = dir_chg_q;
  assign game_over   = game_over_q;

endmodule
